// File: rtl/hps_pwm_bank.sv
`timescale 1ns/1ps
// Purpose: multi-channel PWM bank with double-buffered period/duty, HPS Avalon-MM slave.
// Latency: avs_readdata 1 cycle after avs_read; pwm_out one register stage after counter compare.
// Backpressure: none (no waitrequest); every access completes in one cycle.
//
// Ports:
//   clk_clk, reset_reset_n          single clock, asynchronous active-low reset
//   avs_address/write/writedata     Avalon-MM write port (word addressed)
//   avs_read/readdata               Avalon-MM read port, fixed read latency 1
//   pwm_out[CHANNELS]               registered PWM outputs
//   irq                             level interrupt, high while watchdog expired flag set
//
// Optional feature: define HPS_PWM_WATCHDOG_EN to build the write-activity watchdog.
//
// Register map (word addresses):
//   0 CTRL       bit0 EN, bit1 UPD (write 1 requests update, reads pending)
//   1 PERIOD     staged period
//   2 STATUS     bit0 WDT_EXP (write 1 clears), bit1 update pending
//   3 WDT_RELOAD watchdog reload value, 0 disables
//   4.. DUTY[i]  staged duty per channel

module hps_pwm_bank #(
   parameter int CHANNELS  = 4,
   parameter int CNT_WIDTH = 16,
   parameter int WDT_WIDTH = 24
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic [3:0]          avs_address,
   input  logic                avs_write,
   input  logic [31:0]         avs_writedata,
   input  logic                avs_read,
   output logic [31:0]         avs_readdata,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                irq
);

   typedef logic [CNT_WIDTH-1:0] cnt_t;

   localparam cnt_t CNT_ONE = cnt_t'(1);

   // Control and staged/active register state
   logic                en;
   logic                pending;
   cnt_t                period_stg;
   cnt_t                period_act;
   cnt_t                duty_stg [CHANNELS];
   cnt_t                duty_act [CHANNELS];
   cnt_t                cnt;
   logic                wdt_exp;
   logic [31:0]         wdt_rd;

   // Write decode
   logic                wr_ctrl;
   logic                wr_period;
   logic [CHANNELS-1:0] wr_duty;

   // Period timing
   logic                at_last;
   logic                upd_evt;

   logic [31:0]         rd_nxt;
   logic [CHANNELS-1:0] pwm_nxt;

   // Upper write-data bits and the watchdog width are not used in every build.
   logic                unused_bits;
   assign unused_bits = ^{avs_writedata, WDT_WIDTH[0]};

   assign wr_ctrl   = avs_write && (avs_address == 4'd0);
   assign wr_period = avs_write && (avs_address == 4'd1);

   always_comb begin
      wr_duty = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (avs_write && (avs_address == 4'(i + 4)))
            wr_duty[i] = 1'b1;
      end
   end

   // A zero period holds the counter at 0, so every cycle counts as the
   // end of a period; otherwise an update requested with period_act=0
   // (e.g. the very first one after reset) could never be applied.
   assign at_last = (period_act == '0) || (cnt == period_act - CNT_ONE);

   // While disabled there is no period to align to, so updates apply at once.
   assign upd_evt = pending && (!en || at_last);

   // ------------------------------------------------------------------
   // Period counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         cnt <= '0;
      end else if (!en || at_last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Control, staged and active registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         en         <= 1'b0;
         pending    <= 1'b0;
         period_stg <= '0;
         period_act <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            duty_stg[i] <= '0;
            duty_act[i] <= '0;
         end
      end else begin
         if (wr_ctrl)
            en <= avs_writedata[0];

         if (wr_period)
            period_stg <= avs_writedata[CNT_WIDTH-1:0];

         for (int i = 0; i < CHANNELS; i++) begin
            if (wr_duty[i])
               duty_stg[i] <= avs_writedata[CNT_WIDTH-1:0];
         end

         // Active copies see the staged values as of the previous cycle;
         // a staged write landing on the update cycle waits for the next UPD.
         if (upd_evt) begin
            period_act <= period_stg;
            for (int i = 0; i < CHANNELS; i++)
               duty_act[i] <= duty_stg[i];
         end

         // A fresh request wins over the clear so it is never lost.
         if (wr_ctrl && avs_writedata[1])
            pending <= 1'b1;
         else if (upd_evt)
            pending <= 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Watchdog
   // ------------------------------------------------------------------
`ifdef HPS_PWM_WATCHDOG_EN
   logic                 wr_status;
   logic                 wr_wdt;
   logic [WDT_WIDTH-1:0] wdt_reload;
   logic [WDT_WIDTH-1:0] wdt_cnt;
   logic [WDT_WIDTH-1:0] reload_val;

   assign wr_status = avs_write && (avs_address == 4'd2);
   assign wr_wdt    = avs_write && (avs_address == 4'd3);

   // A write to WDT_RELOAD restarts the count with the value just written.
   assign reload_val = wr_wdt ? avs_writedata[WDT_WIDTH-1:0] : wdt_reload;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wdt_reload <= '0;
         wdt_cnt    <= '0;
         wdt_exp    <= 1'b0;
      end else begin
         if (wr_wdt)
            wdt_reload <= avs_writedata[WDT_WIDTH-1:0];

         // Any bus write is proof of life; a zero reload parks the counter at 0.
         if (avs_write)
            wdt_cnt <= reload_val;
         else if (wdt_cnt != '0)
            wdt_cnt <= wdt_cnt - WDT_WIDTH'(1);

         // Expiry only on the 1->0 step, which a same-cycle write pre-empts.
         if (avs_write) begin
            if (wr_status && avs_writedata[0])
               wdt_exp <= 1'b0;
         end else if (wdt_cnt == WDT_WIDTH'(1)) begin
            wdt_exp <= 1'b1;
         end
      end
   end

   always_comb begin
      wdt_rd                  = '0;
      wdt_rd[WDT_WIDTH-1:0]   = wdt_reload;
   end
`else
   assign wdt_exp = 1'b0;
   assign wdt_rd  = '0;
`endif

   assign irq = wdt_exp;

   // ------------------------------------------------------------------
   // PWM compare and output register
   // ------------------------------------------------------------------
   always_comb begin
      pwm_nxt = '0;
      for (int i = 0; i < CHANNELS; i++)
         pwm_nxt[i] = en && !wdt_exp && (period_act != '0) && (cnt < duty_act[i]);
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)
         pwm_out <= '0;
      else
         pwm_out <= pwm_nxt;
   end

   // ------------------------------------------------------------------
   // Read path: registered, held between reads
   // ------------------------------------------------------------------
   always_comb begin
      rd_nxt = '0;
      case (avs_address)
         4'd0:    rd_nxt[1:0] = {pending, en};
         4'd1:    rd_nxt[CNT_WIDTH-1:0] = period_stg;
         4'd2:    rd_nxt[1:0] = {pending, wdt_exp};
         4'd3:    rd_nxt = wdt_rd;
         default: begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (avs_address == 4'(i + 4))
                  rd_nxt[CNT_WIDTH-1:0] = duty_stg[i];
            end
         end
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)
         avs_readdata <= '0;
      else if (avs_read)
         avs_readdata <= rd_nxt;
   end

endmodule

// File: tb/tb_hps_pwm_bank.sv
`timescale 1ns/1ps
// Directed bench for hps_pwm_bank with default parameters (4 channels).
// Inputs change on the falling edge; outputs are sampled on the falling edge.

module tb_hps_pwm_bank;

   localparam int CH = 4;

   logic          clk_clk       = 1'b0;
   logic          reset_reset_n = 1'b0;
   logic [3:0]    avs_address   = '0;
   logic          avs_write     = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic          avs_read      = 1'b0;
   logic [31:0]   avs_readdata;
   logic [CH-1:0] pwm_out;
   logic          irq;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk_clk = ~clk_clk;

   hps_pwm_bank #(
      .CHANNELS  (CH),
      .CNT_WIDTH (16),
      .WDT_WIDTH (24)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .pwm_out       (pwm_out),
      .irq           (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Presents a write for one cycle; returns at the falling edge after it was sampled.
   task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
      @(negedge clk_clk);
      avs_address   = addr;
      avs_writedata = data;
      avs_write     = 1'b1;
      @(negedge clk_clk);
      avs_write     = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
      @(negedge clk_clk);
      avs_address = addr;
      avs_read    = 1'b1;
      @(negedge clk_clk);
      avs_read    = 1'b0;
      data        = avs_readdata;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      int          h0, h1, hx;
      logic        prev, found;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk_clk);
      chk("rst_pwm", 32'(pwm_out), 0);
      chk("rst_irq", 32'(irq), 0);
      chk("rst_rdata", avs_readdata, 0);
      reset_reset_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         bus_read(4'(a), d);
         chk($sformatf("rst_rd%0d", a), d, 0);
      end
      chk("rst_pwm_after", 32'(pwm_out), 0);

      // ---------------- basic pattern: period 10 ----------------
      bus_write(4'd1, 32'd10);
      bus_write(4'd4, 32'd3);
      bus_write(4'd5, 32'd10);
      bus_write(4'd0, 32'd3);
      // CTRL sampled; active copies load next edge with period_act still 0.
      chk("start_n1", 32'(pwm_out), 0);
      @(negedge clk_clk);
      chk("start_n2", 32'(pwm_out), 0);
      @(negedge clk_clk);
      chk("start_first_hi", 32'(pwm_out), 32'b0011);

      h0 = 0; h1 = 0; hx = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk_clk);
         h0 += int'(pwm_out[0]);
         h1 += int'(pwm_out[1]);
         hx += int'(pwm_out[3:2] != 2'b00);
      end
      chk("duty3_hi_of30", 32'(h0), 9);
      chk("duty_full_hi_of30", 32'(h1), 30);
      chk("idle_ch_hi", 32'(hx), 0);

      // ---------------- period-aligned update, UPD at counter=9 ----------------
      bus_write(4'd4, 32'd7);
      prev  = pwm_out[0];
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk_clk);
         if (prev && !pwm_out[0])
            found = 1'b1;
         prev = pwm_out[0];
      end
      chk("sync_fall", 32'(found), 1);
      // Falling edge seen with counter at 4; the write below is sampled at counter 9.
      repeat (4) @(negedge clk_clk);
      bus_write(4'd0, 32'd3);

      h0 = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk_clk);
         h0 += int'(pwm_out[0]);
         if (i == 1) begin
            avs_address = 4'd2;
            avs_read    = 1'b1;
         end
         if (i == 2) begin
            avs_read = 1'b0;
            chk("pend_set", avs_readdata, 32'h2);
         end
      end
      chk("old_duty_period", 32'(h0), 3);

      h0 = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk_clk);
         h0 += int'(pwm_out[0]);
         if (i == 1) begin
            avs_address = 4'd2;
            avs_read    = 1'b1;
         end
         if (i == 2) begin
            avs_read = 1'b0;
            chk("pend_clr", avs_readdata, 32'h0);
         end
      end
      chk("new_duty_period", 32'(h0), 7);

      bus_read(4'd0, d);
      chk("ctrl_rd", d, 32'h1);
      bus_read(4'd1, d);
      chk("period_rd", d, 32'd10);
      bus_read(4'd4, d);
      chk("duty0_rd", d, 32'd7);

      // ---------------- period 0 ----------------
      bus_write(4'd1, 32'd0);
      bus_write(4'd0, 32'd3);
      repeat (15) @(negedge clk_clk);
      hx = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_clk);
         hx += int'(pwm_out != '0);
      end
      chk("period0_out", 32'(hx), 0);
      bus_read(4'd2, d);
      chk("period0_pend", d, 32'h0);

      // ---------------- update while disabled, then enable ----------------
      bus_write(4'd0, 32'd0);
      bus_write(4'd1, 32'd4);
      bus_write(4'd4, 32'd2);
      bus_write(4'd0, 32'd2);
      @(negedge clk_clk);
      bus_read(4'd2, d);
      chk("en0_upd_pend", d, 32'h0);
      chk("en0_out", 32'(pwm_out), 0);

      bus_write(4'd0, 32'd1);
      chk("en_n1", 32'(pwm_out), 0);
      @(negedge clk_clk);
      chk("en_first_hi", 32'(pwm_out), 32'b0011);
      @(negedge clk_clk);
      chk("en_cnt1", 32'(pwm_out), 32'b0011);
      @(negedge clk_clk);
      chk("en_cnt2", 32'(pwm_out), 32'b0010);
      @(negedge clk_clk);
      chk("en_cnt3", 32'(pwm_out), 32'b0010);
      @(negedge clk_clk);
      chk("en_wrap", 32'(pwm_out), 32'b0011);

      // ---------------- EN 1->0 ----------------
      bus_write(4'd0, 32'd0);
      @(negedge clk_clk);
      chk("en_off_low", 32'(pwm_out), 0);

      // ---------------- asynchronous reset mid-period ----------------
      bus_write(4'd0, 32'd1);
      repeat (3) @(negedge clk_clk);
      chk("pre_rst_hi", 32'(pwm_out[1]), 1);
      #2 reset_reset_n = 1'b0;
      #1;
      chk("async_rst_out", 32'(pwm_out), 0);
      chk("async_rst_irq", 32'(irq), 0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      for (int a = 0; a < 16; a++) begin
         bus_read(4'(a), d);
         chk($sformatf("post_rst_rd%0d", a), d, 0);
      end

      // ---------------- watchdog ----------------
      bus_write(4'd1, 32'd4);
      bus_write(4'd5, 32'd10);
      bus_write(4'd0, 32'd3);
      repeat (3) @(negedge clk_clk);
      chk("wdt_pre_run", 32'(pwm_out[1]), 1);
`ifdef HPS_PWM_WATCHDOG_EN
      bus_write(4'd3, 32'd20);
      repeat (19) @(negedge clk_clk);
      chk("wdt_irq_before", 32'(irq), 0);
      chk("wdt_pwm_before", 32'(pwm_out[1]), 1);
      @(negedge clk_clk);
      chk("wdt_irq_set", 32'(irq), 1);
      @(negedge clk_clk);
      chk("wdt_pwm_forced", 32'(pwm_out), 0);
      bus_read(4'd2, d);
      chk("wdt_status", d, 32'h1);
      bus_read(4'd3, d);
      chk("wdt_reload_rd", d, 32'd20);
      bus_write(4'd2, 32'd1);
      chk("wdt_irq_clr", 32'(irq), 0);
      @(negedge clk_clk);
      chk("wdt_pwm_resume", 32'(pwm_out[1]), 1);
`else
      bus_write(4'd3, 32'd20);
      bus_read(4'd3, d);
      chk("nowdt_reload_rd", d, 0);
      repeat (30) @(negedge clk_clk);
      chk("nowdt_irq", 32'(irq), 0);
      chk("nowdt_pwm_run", 32'(pwm_out[1]), 1);
      bus_read(4'd2, d);
      chk("nowdt_status", d, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
